kmkz_regfile_mp: RTL

//  Parametrised successor of the 2R1W integer register file. Supports XLEN width,
//  RV32I/RV32E depth, and NRD read ports. Decode presents read addresses; the

---
 rtl/kmkz_pkg.sv | 18 +
 rtl/kmkz_rf_bypass.sv | 49 ++++
 rtl/kmkz_regfile_mp.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/kmkz_pkg.sv
// Shared definitions for the parametrised integer register file.
// Exports: REG_AW (register address width), rf_state_t (clear/run sequencer states),
//          addr_in_range() (true for a writable/readable architectural register).
package kmkz_pkg;

  localparam int REG_AW = 5;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  // x0 is hard-wired zero and anything at or above nregs does not exist (RV32E).
  function automatic logic addr_in_range(input logic [REG_AW-1:0] addr, input int nregs);
    return (addr != '0) && (32'(addr) < nregs);
  endfunction

endpackage

// File: rtl/kmkz_rf_bypass.sv
// One operand port's forwarding logic: the registered writeback-bypass flag and the
// final operand priority mux (execute result, then writeback value, then array read).
// Ports: clk_i/rst_i/d_stall_i control; regfile_write, w_rd, rf_rs, d_rs address compare;
//        byp_x_en/byp_x_value execute forward; bypass_w writeback forward; operand in; value out.
module kmkz_rf_bypass
  import kmkz_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              d_stall_i,
  input  logic              regfile_write,
  input  logic [REG_AW-1:0] w_rd,
  input  logic [REG_AW-1:0] rf_rs,
  input  logic [REG_AW-1:0] d_rs,
  input  logic              byp_x_en,
  input  logic [XLEN-1:0]   byp_x_value,
  input  logic [XLEN-1:0]   bypass_w,
  input  logic [XLEN-1:0]   operand,
  output logic [XLEN-1:0]   value
);

  logic byp_w_q;
  logic byp_x;

  // The operand register sampled the array in the same cycle a write to that
  // register landed, so it holds the stale value; remember to take bypass_w instead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byp_w_q <= 1'b0;
    end else if (!d_stall_i) begin
      byp_w_q <= regfile_write & (rf_rs == w_rd);
    end
  end

  assign byp_x = byp_x_en & (w_rd == d_rs) & (w_rd != '0);

  // Younger result wins: execute forward beats writeback forward beats the array.
  always_comb begin
    value = operand;
    if (byp_x) begin
      value = byp_x_value;
    end else if (byp_w_q) begin
      value = bypass_w;
    end
  end

endmodule

// File: rtl/kmkz_regfile_mp.sv
// Parametrised NRD-read / 1-write integer register file with registered, bypass-corrected
// operands, a post-reset clear sequencer (busy_o) and a one-cycle debug read port.
// Ports: clk_i, rst_i (sync, active high), d_stall_i; rf_rs_i/d_rs_i read addresses;
//        x_rs_value_o operands; w_rd_* writeback; w_bypass_rd_* execute forward;
//        dbg_addr_i/dbg_re_i -> dbg_rdata_o/dbg_valid_o; busy_o while clearing.
module kmkz_regfile_mp
  import kmkz_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int NRD            = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   d_stall_i,
  input  logic [NRD*REG_AW-1:0]  rf_rs_i,
  input  logic [NRD*REG_AW-1:0]  d_rs_i,
  output logic [NRD*XLEN-1:0]    x_rs_value_o,
  input  logic [REG_AW-1:0]      w_rd_i,
  input  logic [XLEN-1:0]        w_rd_value_i,
  input  logic                   w_rd_store_i,
  input  logic                   w_bypass_rd_write_i,
  input  logic [XLEN-1:0]        w_bypass_rd_value_i,
  input  logic [REG_AW-1:0]      dbg_addr_i,
  input  logic                   dbg_re_i,
  output logic [XLEN-1:0]        dbg_rdata_o,
  output logic                   dbg_valid_o,
  output logic                   busy_o
);

  localparam rf_state_t         RESET_STATE = (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_RUN;
  localparam logic [REG_AW-1:0] LAST_IDX    = REG_AW'(NREGS - 1);

  rf_state_t         state;
  rf_state_t         state_nxt;
  logic [REG_AW-1:0] clr_idx;
  logic [REG_AW-1:0] clr_idx_nxt;
  logic              run;
  logic              regfile_write;

  logic              arr_we;
  logic [REG_AW-1:0] arr_waddr;
  logic [XLEN-1:0]   arr_wdata;

  // x0 has no storage; it reads as zero through the read muxes.
  logic [XLEN-1:0]   regs [1:NREGS-1];
  logic [XLEN-1:0]   rd_val [NRD];
  logic [XLEN-1:0]   op_q [NRD];
  logic [XLEN-1:0]   bypass_w;
  logic [XLEN-1:0]   dbg_val;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= RESET_STATE;
      clr_idx <= REG_AW'(1);
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      RF_CLEAR: begin
        clr_idx_nxt = clr_idx + REG_AW'(1);
        if (clr_idx == LAST_IDX) begin
          state_nxt = RF_RUN;
        end
      end
      default: begin
      end
    endcase
  end

  assign run    = (state == RF_RUN);
  assign busy_o = (state == RF_CLEAR);

  // ---------------- write port ----------------
  assign regfile_write = run & w_rd_store_i & addr_in_range(w_rd_i, NREGS);

  // The clear sequencer owns the single array write port until it finishes.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = '0;
    arr_wdata = '0;
    if (!rst_i) begin
      if (!run) begin
        arr_we    = 1'b1;
        arr_waddr = clr_idx;
      end else if (regfile_write) begin
        arr_we    = 1'b1;
        arr_waddr = w_rd_i;
        arr_wdata = w_rd_value_i;
      end
    end
  end

  // No reset on the array: the clear sequencer zeroes it instead.
  always_ff @(posedge clk_i) begin
    for (int i = 1; i < NREGS; i++) begin
      if (arr_we && (arr_waddr == REG_AW'(i))) begin
        regs[i] <= arr_wdata;
      end
    end
  end

  // ---------------- read muxes ----------------
  // Addresses 0 and >= NREGS match no entry and fall through to zero.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_val[k] = '0;
      for (int i = 1; i < NREGS; i++) begin
        if (rf_rs_i[k*REG_AW +: REG_AW] == REG_AW'(i)) begin
          rd_val[k] = regs[i];
        end
      end
    end
  end

  always_comb begin
    dbg_val = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (dbg_addr_i == REG_AW'(i)) begin
        dbg_val = regs[i];
      end
    end
  end

  // ---------------- operand / forward / debug registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i || !run) begin
      for (int k = 0; k < NRD; k++) begin
        op_q[k] <= '0;
      end
    end else if (!d_stall_i) begin
      for (int k = 0; k < NRD; k++) begin
        op_q[k] <= rd_val[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bypass_w    <= '0;
      dbg_rdata_o <= '0;
      dbg_valid_o <= 1'b0;
    end else begin
      if (regfile_write) begin
        bypass_w <= w_rd_value_i;
      end
      dbg_valid_o <= run & dbg_re_i;
      if (run && dbg_re_i) begin
        dbg_rdata_o <= dbg_val;
      end
    end
  end

  // ---------------- per-port forwarding ----------------
  for (genvar k = 0; k < NRD; k++) begin : g_port
    kmkz_rf_bypass #(
      .XLEN(XLEN)
    ) u_byp (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .d_stall_i    (d_stall_i),
      .regfile_write(regfile_write),
      .w_rd         (w_rd_i),
      .rf_rs        (rf_rs_i[k*REG_AW +: REG_AW]),
      .d_rs         (d_rs_i[k*REG_AW +: REG_AW]),
      .byp_x_en     (w_bypass_rd_write_i),
      .byp_x_value  (w_bypass_rd_value_i),
      .bypass_w     (bypass_w),
      .operand      (op_q[k]),
      .value        (x_rs_value_o[k*XLEN +: XLEN])
    );
  end

endmodule
